// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples SCK/WS/SD in the clk domain and commits
// left/right samples. Define I2S_RX_SLOT_ERR_EN to enable slot-length error pulses.
module i2s_rx #(
  parameter int AUDIO_DW = 8,
  parameter int CNT_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                sck_i,
  input  logic                ws_i,
  input  logic                sd_i,
  output logic [AUDIO_DW-1:0] l_data_o,
  output logic [AUDIO_DW-1:0] r_data_o,
  output logic                l_valid_o,
  output logic                r_valid_o,
  output logic                locked_o,
  output logic                slot_err_o
);

  localparam int unsigned      DW      = AUDIO_DW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef I2S_RX_SLOT_ERR_EN
  localparam bit SLOT_ERR_EN = 1'b1;
`else
  localparam bit SLOT_ERR_EN = 1'b0;
`endif

  // HUNT: waiting for the first WS edge; RELOAD: next rise only reloads ws_prev
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          sck_sync;
  logic [1:0]          ws_sync;
  logic [1:0]          sd_sync;
  logic                sck_d;
  logic                rise_q;
  logic                ws_q;
  logic                sd_q;
  logic                ws_prev;
  logic [AUDIO_DW-1:0] shift;
  logic [AUDIO_DW-1:0] shift_wr;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                slot_bad;

  // Shift register with the current bit placed MSB-first; bits past AUDIO_DW drop out.
  always_comb begin
    shift_wr = shift;
    for (int unsigned i = 0; i < DW; i++) begin
      if (32'(cnt) == DW - 1 - i) shift_wr[i] = sd_q;
    end
  end

  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign slot_bad = (cnt == CNT_MAX) || (32'(cnt) + 32'd1 != DW);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      sck_sync   <= '0;
      ws_sync    <= '0;
      sd_sync    <= '0;
      sck_d      <= 1'b0;
      rise_q     <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      ws_prev    <= 1'b0;
      shift      <= '0;
      cnt        <= '0;
      l_data_o   <= '0;
      r_data_o   <= '0;
      l_valid_o  <= 1'b0;
      r_valid_o  <= 1'b0;
      locked_o   <= 1'b0;
      slot_err_o <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[0], sck_i};
      ws_sync    <= {ws_sync[0], ws_i};
      sd_sync    <= {sd_sync[0], sd_i};
      sck_d      <= sck_sync[1];
      // ws/sd are registered alongside the rise flag so they stay aligned with it
      rise_q     <= sck_sync[1] & ~sck_d;
      ws_q       <= ws_sync[1];
      sd_q       <= sd_sync[1];
      l_valid_o  <= 1'b0;
      r_valid_o  <= 1'b0;
      slot_err_o <= 1'b0;

      if (!en_i) begin
        state    <= ST_RELOAD;
        locked_o <= 1'b0;
        cnt      <= '0;
        shift    <= '0;
      end else if (rise_q) begin
        ws_prev <= ws_q;
        if (state == ST_RELOAD || ws_q == ws_prev) begin
          shift <= shift_wr;
          cnt   <= cnt_inc;
          if (state == ST_RELOAD) state <= ST_HUNT;
        end else begin
          // Boundary rise carries the LSB of the slot that just ended
          if (state == ST_LOCKED) begin
            if (ws_prev) begin
              r_data_o  <= shift_wr;
              r_valid_o <= 1'b1;
            end else begin
              l_data_o  <= shift_wr;
              l_valid_o <= 1'b1;
            end
            slot_err_o <= SLOT_ERR_EN & slot_bad;
          end
          shift    <= '0;
          cnt      <= '0;
          state    <= ST_LOCKED;
          locked_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: directed I2S frames checked every cycle against a slot-level model.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_i = 1'b1;
  logic          sck_i = 1'b0;
  logic          ws_i = 1'b0;
  logic          sd_i = 1'b0;
  logic [DW-1:0] l_data_o;
  logic [DW-1:0] r_data_o;
  logic          l_valid_o;
  logic          r_valid_o;
  logic          locked_o;
  logic          slot_err_o;

  i2s_rx #(.AUDIO_DW(DW), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .sck_i      (sck_i),
    .ws_i       (ws_i),
    .sd_i       (sd_i),
    .l_data_o   (l_data_o),
    .r_data_o   (r_data_o),
    .l_valid_o  (l_valid_o),
    .r_valid_o  (r_valid_o),
    .locked_o   (locked_o),
    .slot_err_o (slot_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int half     = 4;
  int l_pulses = 0;
  int r_pulses = 0;
  int e_pulses = 0;
  int commit_drv_cyc = -100;
  int clr_at    = -1;
  int unlock_at = -1;

  typedef struct {
    bit            lock;
    bit            commit;
    bit            ch;
    logic [DW-1:0] data;
    bit            err;
  } ev_t;

  ev_t           evq[64];
  bit            evv[64];
  bit            m_en = 1'b1;
  bit            m_locked = 1'b0;
  bit            m_reload = 1'b0;
  bit            m_prev = 1'b0;
  bit            bits[$];
  logic [DW-1:0] exp_l = '0;
  logic [DW-1:0] exp_r = '0;
  bit            exp_lv, exp_rv, exp_err;
  bit            exp_locked = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Protocol model: collect bits of a slot; a WS change closes the slot with this bit as LSB.
  task automatic model_rise(input bit ws, input bit sd);
    ev_t e;
    logic [DW-1:0] w;
    if (!m_en) return;
    bits.push_back(sd);
    if (!m_reload && ws != m_prev) begin
      e = '{default: 0};
      e.lock = 1'b1;
      if (m_locked) begin
        w = '0;
        for (int i = 0; i < DW && i < bits.size(); i++) w[DW-1-i] = bits[i];
        e.commit = 1'b1;
        e.ch     = m_prev;
        e.data   = w;
        e.err    = (bits.size() != DW);
        commit_drv_cyc = cyc;
      end
      evq[(cyc + 4) % 64] = e;
      evv[(cyc + 4) % 64] = 1'b1;
      bits.delete();
      m_locked = 1'b1;
    end
    m_reload = 1'b0;
    m_prev   = ws;
  endtask

  // Compare process: every cycle, shortly after the active edge.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      exp_lv  = 1'b0;
      exp_rv  = 1'b0;
      exp_err = 1'b0;
      if (cyc == clr_at) begin
        exp_l = '0;
        exp_r = '0;
        exp_locked = 1'b0;
      end
      if (cyc == unlock_at) exp_locked = 1'b0;
      if (evv[cyc % 64]) begin
        evv[cyc % 64] = 1'b0;
        e = evq[cyc % 64];
        if (e.lock) exp_locked = 1'b1;
        if (e.commit) begin
          if (e.ch) begin exp_r = e.data; exp_rv = 1'b1; end
          else      begin exp_l = e.data; exp_lv = 1'b1; end
`ifdef I2S_RX_SLOT_ERR_EN
          exp_err = e.err;
`endif
        end
      end
      chk("l_valid", l_valid_o, exp_lv);
      chk("r_valid", r_valid_o, exp_rv);
      chk("l_data", l_data_o, exp_l);
      chk("r_data", r_data_o, exp_r);
      chk("locked", locked_o, exp_locked);
      chk("slot_err", slot_err_o, exp_err);
      chk("valid_onehot", l_valid_o & r_valid_o, 0);
      if (l_valid_o === 1'b1) l_pulses++;
      if (r_valid_o === 1'b1) r_pulses++;
      if (slot_err_o === 1'b1) e_pulses++;
      if (l_valid_o === 1'b1 || r_valid_o === 1'b1)
        chk("valid_latency", cyc - commit_drv_cyc, 4);
    end
  end

  task automatic send_bit(input bit ws, input bit sd);
    @(negedge clk);
    sck_i = 1'b0;
    ws_i  = ws;
    sd_i  = sd;
    repeat (half) @(negedge clk);
    sck_i = 1'b1;
    model_rise(ws, sd);
    repeat (half - 1) @(negedge clk);
  endtask

  // Philips framing: last bit of a slot already carries the next WS value.
  task automatic send_slot(input bit ch, input logic [15:0] word, input int n, input bit nxt);
    for (int i = 0; i < n; i++) send_bit((i == n - 1) ? nxt : ch, word[n-1-i]);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic ctl_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bits.delete();
    m_locked = 1'b0;
    m_prev   = 1'b0;
    m_reload = 1'b0;
    clr_at   = cyc + 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic ctl_en(input bit v);
    @(negedge clk);
    en_i = v;
    if (!v) begin
      m_en = 1'b0;
      m_locked = 1'b0;
      m_reload = 1'b1;
      bits.delete();
      unlock_at = cyc + 1;
    end else begin
      m_en = 1'b1;
    end
  endtask

  initial begin
    int l0, r0, e0;
    logic [7:0] a5, lw, rw;
    a5 = 8'hA5;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Nominal: first left slot is discarded, then every slot commits
    half = 4;
    send_slot(0, 16'h00A5, 8, 1);
    settle();
    chk("first_slot_discarded", l_pulses, 0);
    chk("locked_after_ws_edge", locked_o, 1);
    send_slot(1, 16'h003C, 8, 0);
    for (int f = 0; f < 3; f++) begin
      send_slot(0, 16'h00A5, 8, 1);
      send_slot(1, 16'h003C, 8, 0);
    end
    settle();
    chk("nominal_l_count", l_pulses, 3);
    chk("nominal_r_count", r_pulses, 4);
    chk("nominal_l_data", l_data_o, 8'hA5);
    chk("nominal_r_data", r_data_o, 8'h3C);

    // Long left slot truncated
    e0 = e_pulses;
    send_slot(0, 16'h0A5F, 12, 1);
    send_slot(1, 16'h003C, 8, 0);
    settle();
    chk("long_l_data", l_data_o, 8'hA5);
    chk("long_r_data", r_data_o, 8'h3C);
`ifdef I2S_RX_SLOT_ERR_EN
    chk("long_err_count", e_pulses - e0, 1);
`else
    chk("long_err_count", e_pulses - e0, 0);
`endif

    // Short left slot zero-padded
    e0 = e_pulses;
    send_slot(0, 16'h002D, 6, 1);
    send_slot(1, 16'h003C, 8, 0);
    settle();
    chk("short_l_data", l_data_o, 8'hB4);
`ifdef I2S_RX_SLOT_ERR_EN
    chk("short_err_count", e_pulses - e0, 1);
`else
    chk("short_err_count", e_pulses - e0, 0);
`endif

    // Enable gating mid-slot
    for (int i = 0; i < 4; i++) send_bit(0, a5[7-i]);
    ctl_en(0);
    l0 = l_pulses;
    r0 = r_pulses;
    for (int i = 4; i < 8; i++) send_bit((i == 7) ? 1'b1 : 1'b0, a5[7-i]);
    send_slot(1, 16'h003C, 8, 0);
    for (int f = 0; f < 3; f++) begin
      send_slot(0, 16'h00A5, 8, 1);
      send_slot(1, 16'h003C, 8, 0);
    end
    send_bit(0, a5[7]);
    send_bit(0, a5[6]);
    settle();
    chk("dis_l_pulses", l_pulses - l0, 0);
    chk("dis_r_pulses", r_pulses - r0, 0);
    chk("dis_l_hold", l_data_o, 8'hB4);
    chk("dis_locked", locked_o, 0);
    ctl_en(1);
    for (int i = 2; i < 8; i++) send_bit((i == 7) ? 1'b1 : 1'b0, a5[7-i]);
    settle();
    chk("reen_no_commit", (l_pulses - l0) + (r_pulses - r0), 0);
    chk("reen_locked", locked_o, 1);
    send_slot(1, 16'h003C, 8, 0);
    settle();
    chk("reen_r_count", r_pulses - r0, 1);
    chk("reen_l_count", l_pulses - l0, 0);
    send_slot(0, 16'h0069, 8, 1);
    settle();
    chk("reen_l_data", l_data_o, 8'h69);

    // Reset during bit 3 of a left slot
    send_slot(1, 16'h003C, 8, 0);
    for (int i = 0; i < 4; i++) send_bit(0, a5[7-i]);
    ctl_reset();
    chk("rst_l_data", l_data_o, 0);
    chk("rst_r_data", r_data_o, 0);
    chk("rst_locked", locked_o, 0);
    l0 = l_pulses;
    for (int i = 4; i < 8; i++) send_bit((i == 7) ? 1'b1 : 1'b0, a5[7-i]);
    send_slot(1, 16'h003C, 8, 0);
    settle();
    chk("rst_no_l_commit", l_pulses - l0, 0);
    chk("rst_r_resume", r_data_o, 8'h3C);
    send_slot(0, 16'h005A, 8, 1);
    send_slot(1, 16'h00C3, 8, 0);
    settle();
    chk("rst_l_resume", l_data_o, 8'h5A);
    chk("rst_r_resume2", r_data_o, 8'hC3);

    // Minimum SCK timing, random data
    half = 4;
    half = 2;
    l0 = l_pulses;
    r0 = r_pulses;
    lw = '0;
    rw = '0;
    for (int f = 0; f < 100; f++) begin
      lw = 8'($urandom);
      rw = 8'($urandom);
      send_slot(0, {8'h00, lw}, 8, 1);
      send_slot(1, {8'h00, rw}, 8, 0);
    end
    settle();
    chk("min_l_count", l_pulses - l0, 100);
    chk("min_r_count", r_pulses - r0, 100);
    chk("min_last_l", l_data_o, lw);
    chk("min_last_r", r_data_o, rw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver. Deserialises an external Philips-format I2S stream (SCK/WS/SD) into left and right parallel samples in the system clock domain.
- Companion to the team's i2s_tx. Used for external audio input and for tx->rx loopback at a divided bit rate.
- Feeds the register map status bytes and the sample-select mux.
- Oversamples SCK/WS/SD asynchronously. No SCK-domain flops.

Parameters:
- AUDIO_DW, 8, sample width in bits per channel. Must be >= 2.
- CNT_W, 5, width of the per-slot bit counter. The counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en_i  in  1  receive enable
- sck_i  in  1  I2S bit clock, asynchronous
- ws_i  in  1  I2S word select, asynchronous; 0=left, 1=right
- sd_i  in  1  I2S serial data, asynchronous
- l_data_o  out  AUDIO_DW  last committed left sample
- r_data_o  out  AUDIO_DW  last committed right sample
- l_valid_o  out  1  one-clk pulse when l_data_o is updated
- r_valid_o  out  1  one-clk pulse when r_data_o is updated
- locked_o  out  1  high once a WS edge has been seen since reset or enable
- slot_err_o  out  1  slot-length error pulse (see Optional Feature)

Behaviour:
- Clock and reset:
  - Clock clk; reset rst_n is synchronous and active-low.
  - In reset, every flop clears: l_data_o=0, r_data_o=0, l_valid_o=0, r_valid_o=0, locked_o=0, slot_err_o=0, shift register=0, bit counter=0, previous-WS=0.
- Input timing constraint:
  - SCK high and low phases each >= 2 clk, so SCK period >= 4 clk.
  - Behaviour outside this constraint is undefined.
- Synchronisers:
  - 2-flop synchroniser on each of sck_i, ws_i, sd_i.
  - A third SCK flop provides rise detection: rise = sync_sck & ~sck_d.
- Action on each detected rise, using the synchronised ws and sd:
  - Case ws == ws_prev (mid-slot): if cnt < AUDIO_DW, write sd into shift[AUDIO_DW-1-cnt]. Then cnt <= cnt+1, saturating.
  - Case ws != ws_prev (boundary, per I2S: the bit at the WS-change rise is the LSB of the old slot):
    - Write sd into shift[AUDIO_DW-1-cnt] if cnt < AUDIO_DW.
    - If locked_o, commit the completed word to the channel of ws_prev (0 -> l_data_o, 1 -> r_data_o).
    - Then clear the shift register and set cnt <= 0. Set locked_o <= 1.
  - ws_prev <= ws on every rise.
- Commit semantics:
  - Outputs are MSB-first and left-justified.
  - Short slots (< AUDIO_DW bits) are zero-padded in the LSBs.
  - Long slots are truncated: bits beyond AUDIO_DW are ignored.
  - The committed value includes the boundary bit.
- Valid strobes:
  - Data output and matching valid pulse register in the same clk cycle, one cycle after the rise-detect cycle.
  - Latency from a physical SCK rise to the valid pulse is 4 clk (2 sync + edge + commit).
  - Data holds until the next commit. Valid pulses are exactly 1 clk wide.
  - l_valid_o and r_valid_o are never high together.
- First partial slot after reset or enable is discarded: locked_o=0 suppresses the commit.
- en_i=0:
  - Rise processing stops. locked_o <= 0, cnt <= 0, shift <= 0, no valid pulses.
  - l_data_o and r_data_o hold their values.
  - On re-enable, ws_prev is reloaded from the synchronised ws at the first rise, and that rise is not treated as a boundary.
- Reset mid-slot: all state clears on the next clk. The in-progress word is lost and the next full slot after a WS edge is the first committed.
- SD stuck high or low: produces 0xFF / 0x00 samples. No error is flagged.

Optional Feature:
- Macro: I2S_RX_SLOT_ERR_EN.
- Defined:
  - slot_err_o pulses coincident with l_valid_o or r_valid_o when the committed slot's total bit count (cnt+1 at the boundary) != AUDIO_DW.
  - Saturated counts are treated as a mismatch.
- Undefined: slot_err_o is tied to 0 and the port remains present, so the interface is identical in both builds.

Test Plan:
- Nominal 8-bit: AUDIO_DW=8, SCK period 8 clk, 8-bit slots, frames L=0xA5 R=0x3C sent repeatedly. Required:
  - The first slot is discarded.
  - Then l_data_o=0xA5 and r_data_o=0x3C.
  - Each valid pulses once per frame, 1 clk wide, 4 clk after the boundary SCK rise.
  - locked_o=1 after the first WS edge.
- Long slot: 12-bit left slot 0xA5F, 8-bit right slot 0x3C. Required: l_data_o=0xA5, r_data_o=0x3C; with the macro, slot_err_o pulses with l_valid_o only.
- Short slot: 6-bit left slot 101101b. Required: l_data_o=0xB4; with the macro, slot_err_o=1 on that commit.
- Enable gating: drop en_i mid-slot during 0xA5, hold it low 3 frames, then raise it. Required:
  - No valid pulses while en_i is low, and l_data_o holds its previous value.
  - locked_o=0 while en_i is low.
  - After re-enable, the first commit occurs only after a WS edge and one full slot.
- Reset mid-slot: assert rst_n=0 for 1 clk in bit 3 of the left slot. Required:
  - All outputs are 0 on the next clk.
  - No commit for the interrupted slot.
  - Correct samples resume after re-lock.
- Minimum SCK timing: SCK period 4 clk (2 high, 2 low) with random L/R data for 100 frames. Required: every received sample matches the transmitted sample, and pulse counts are equal for left and right.
